// File: rtl/pcie_phy_pkg.sv
// Shared PHY logical-layer symbols and framer state encodings.
// Used by the transmit framer and its SKP scheduler.
package pcie_phy_pkg;

  localparam logic [7:0] K_STP  = 8'hFB;
  localparam logic [7:0] K_SDP  = 8'h5C;
  localparam logic [7:0] K_END  = 8'hFD;
  localparam logic [7:0] K_EDB  = 8'hFE;
  localparam logic [7:0] K_PAD  = 8'hF7;
  localparam logic [7:0] K_COM  = 8'hBC;
  localparam logic [7:0] K_SKP  = 8'h1C;
  localparam logic [7:0] D_IDLE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PKT,
    ST_TAIL,
    ST_DROP,
    ST_SKP
  } framer_state_t;

endpackage

// File: rtl/tx_skp_scheduler.sv
// SKP ordered-set interval counter; raises skp_pending on expiry,
// held until the framer reports the set was sent.
module tx_skp_scheduler #(
  parameter int SKP_INTERVAL = 295,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic skp_taken,
  output logic skp_pending
);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (cnt == CNT_W'(SKP_INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt         <= '0;
      skp_pending <= 1'b0;
    end else begin
      cnt <= expire ? '0 : cnt + CNT_W'(1);
      if (expire)
        skp_pending <= 1'b1;
      else if (skp_taken)
        skp_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_packet_framer.sv
// Gen1/Gen2 transmit framer: start/end/pad insertion, logical idle
// and SKP ordered sets on a single byte stream.
module tx_packet_framer
  import pcie_phy_pkg::*;
#(
  parameter int BYTES        = 4,
  parameter int SKP_INTERVAL = 295,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [2:0]         in_last_cnt,
  input  logic               in_dllp,
  input  logic               in_nullify,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_dk,
  output logic               out_valid,
  output logic               underrun
);

  localparam int W = 8 * BYTES;

  framer_state_t    state, state_nxt;
  logic [7:0]       carry, carry_nxt;
  logic             dllp, dllp_nxt;
  logic [W-1:0]     tail_data, tail_data_nxt;
  logic [BYTES-1:0] tail_dk, tail_dk_nxt;
  logic [W-1:0]     data_nxt;
  logic [BYTES-1:0] dk_nxt;
  logic             underrun_nxt;
  logic             skp_pending, skp_taken;
  logic             accept, is_dllp, split, load;
  logic [7:0]       lead, end_sym;
  logic [W-1:0]     frm_data, frm_tail;
  logic [BYTES-1:0] frm_dk, frm_tail_dk;
  int               n;

  tx_skp_scheduler #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .CNT_W       (CNT_W)
  ) u_skp (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .skp_taken  (skp_taken),
    .skp_pending(skp_pending)
  );

  always_comb begin
    in_ready = 1'b0;
    if (!rst && en) begin
      unique case (state)
        ST_IDLE:         in_ready = !skp_pending;
        ST_PKT, ST_DROP: in_ready = 1'b1;
        default:         in_ready = 1'b0;
      endcase
    end
  end

  assign accept  = in_valid && in_ready;
  assign is_dllp = (state == ST_IDLE) ? in_dllp : dllp;
  assign end_sym = (in_nullify && !is_dllp) ? K_EDB : K_END;
  assign lead    = (state == ST_IDLE) ? (in_dllp ? K_SDP : K_STP) : carry;
  assign load    = (state == ST_IDLE && !skp_pending && accept && in_sop)
                || (state == ST_PKT && in_valid);

  // Word layout: leading symbol, then data, then end symbol and PAD.
  // A word too full for the end symbol spills into the TAIL word.
  always_comb begin
    n = int'(in_last_cnt);
    if (n == 0 || n > BYTES)
      n = BYTES;
    frm_data      = '0;
    frm_dk        = '0;
    frm_tail      = '0;
    frm_tail_dk   = '0;
    frm_data[7:0] = lead;
    frm_dk[0]     = (state == ST_IDLE);
    for (int i = 1; i < BYTES; i++) begin
      if (!in_eop || i - 1 < n) begin
        frm_data[8*i +: 8] = in_data[8*(i-1) +: 8];
      end else begin
        frm_dk[i]          = 1'b1;
        frm_data[8*i +: 8] = (i - 1 == n) ? end_sym : K_PAD;
      end
    end
    for (int j = 0; j < BYTES; j++) begin
      if (j + BYTES - 1 < n) begin
        frm_tail[8*j +: 8] = in_data[W-8 +: 8];
      end else begin
        frm_tail_dk[j]     = 1'b1;
        frm_tail[8*j +: 8] = (j + BYTES - 1 == n) ? end_sym : K_PAD;
      end
    end
    split = in_eop && (n >= BYTES - 1);
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (skp_pending)
            state_nxt = ST_SKP;
          else if (load)
            state_nxt = !in_eop ? ST_PKT : (split ? ST_TAIL : ST_IDLE);
        end
        ST_PKT: begin
          if (!in_valid)
            state_nxt = ST_DROP;
          else if (in_eop)
            state_nxt = split ? ST_TAIL : ST_IDLE;
        end
        ST_DROP: begin
          if (accept && in_eop)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_nxt      = {BYTES{D_IDLE}};
    dk_nxt        = '0;
    underrun_nxt  = 1'b0;
    carry_nxt     = carry;
    dllp_nxt      = dllp;
    tail_data_nxt = tail_data;
    tail_dk_nxt   = tail_dk;
    skp_taken     = 1'b0;
    if (en) begin
      if (state == ST_IDLE && skp_pending) begin
        for (int i = 0; i < BYTES; i++)
          data_nxt[8*i +: 8] = (i == 0) ? K_COM : K_SKP;
        dk_nxt = '1;
      end else if (state == ST_PKT && !in_valid) begin
        for (int i = 0; i < BYTES; i++)
          data_nxt[8*i +: 8] = (i == 0) ? carry : (i == 1) ? K_EDB : K_PAD;
        dk_nxt       = '1;
        dk_nxt[0]    = 1'b0;
        underrun_nxt = 1'b1;
      end else if (load) begin
        data_nxt      = frm_data;
        dk_nxt        = frm_dk;
        carry_nxt     = in_data[W-8 +: 8];
        tail_data_nxt = frm_tail;
        tail_dk_nxt   = frm_tail_dk;
        if (state == ST_IDLE)
          dllp_nxt = in_dllp;
      end else if (state == ST_TAIL) begin
        data_nxt = tail_data;
        dk_nxt   = tail_dk;
      end else if (state == ST_SKP) begin
        skp_taken = 1'b1;
        // Narrow bus: second half of COM,SKP,SKP,SKP.
        if (BYTES < 4) begin
          data_nxt = {BYTES{K_SKP}};
          dk_nxt   = '1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      carry     <= '0;
      dllp      <= 1'b0;
      tail_data <= '0;
      tail_dk   <= '0;
      out_data  <= '0;
      out_dk    <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      carry     <= carry_nxt;
      dllp      <= dllp_nxt;
      tail_data <= tail_data_nxt;
      tail_dk   <= tail_dk_nxt;
      out_data  <= data_nxt;
      out_dk    <= dk_nxt;
      out_valid <= en;
      underrun  <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_tx_packet_framer.sv
// Bench for tx_packet_framer: per-cycle expected words from a
// byte-stream framing model, compared one cycle later.
module tb_tx_packet_framer;
  import pcie_phy_pkg::*;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [BYTES-1:0] dk;
    logic             urun;
    logic             vld;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, en, in_valid, in_ready;
  logic [W-1:0]     in_data, out_data;
  logic             in_sop, in_eop, in_dllp, in_nullify;
  logic [2:0]       in_last_cnt;
  logic [BYTES-1:0] out_dk;
  logic             out_valid, underrun;

  exp_t       q[$];
  exp_t       fw[$];
  exp_t       mon_e;
  logic [7:0] pb[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  tx_packet_framer #(
    .BYTES       (BYTES),
    .SKP_INTERVAL(8),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_last_cnt(in_last_cnt),
    .in_dllp    (in_dllp),
    .in_nullify (in_nullify),
    .out_data   (out_data),
    .out_dk     (out_dk),
    .out_valid  (out_valid),
    .underrun   (underrun)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("data", 64'(out_data), 64'(mon_e.data));
      check("dk", 64'(out_dk), 64'(mon_e.dk));
      check("underrun", 64'(underrun), 64'(mon_e.urun));
      check("valid", 64'(out_valid), 64'(mon_e.vld));
    end
  end

  function automatic exp_t idle_e(logic v);
    exp_t e;
    e     = '0;
    e.vld = v;
    return e;
  endfunction

  function automatic exp_t com_e();
    exp_t e;
    e      = idle_e(1'b1);
    e.data = {K_SKP, K_SKP, K_SKP, K_COM};
    e.dk   = '1;
    return e;
  endfunction

  task automatic step(exp_t e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_sop      = 1'b0;
    in_eop      = 1'b0;
    in_last_cnt = 3'd0;
    in_dllp     = 1'b0;
    in_nullify  = 1'b0;
    in_data     = '0;
  endtask

  task automatic restart();
    idle_in();
    en = 1'b0;
    #1;
    check("en_off_rdy", 64'(in_ready), 64'(0));
    step(idle_e(1'b0));
    en = 1'b1;
  endtask

  task automatic make_pkt(int len);
    pb.delete();
    for (int i = 0; i < len; i++)
      pb.push_back(8'($urandom));
  endtask

  // Expected symbol stream: start, nb payload bytes, end, PAD to word.
  task automatic frame(logic [7:0] start, int nb, logic [7:0] endsym);
    logic [7:0] st[$];
    logic       sk[$];
    exp_t       e;
    fw.delete();
    st.push_back(start);
    sk.push_back(1'b1);
    for (int i = 0; i < nb; i++) begin
      st.push_back(pb[i]);
      sk.push_back(1'b0);
    end
    st.push_back(endsym);
    sk.push_back(1'b1);
    while (st.size() % BYTES != 0) begin
      st.push_back(K_PAD);
      sk.push_back(1'b1);
    end
    for (int k = 0; k < st.size() / BYTES; k++) begin
      e = idle_e(1'b1);
      for (int i = 0; i < BYTES; i++) begin
        e.data[8*i +: 8] = st[BYTES*k+i];
        e.dk[i]          = sk[BYTES*k+i];
      end
      fw.push_back(e);
    end
  endtask

  task automatic drive_word(int k, logic dllp, logic nul, logic zc);
    int nin, last;
    nin         = (pb.size() + BYTES - 1) / BYTES;
    last        = pb.size() - BYTES * (nin - 1);
    in_valid    = 1'b1;
    in_sop      = (k == 0);
    in_eop      = (k == nin - 1);
    in_last_cnt = (zc && last == BYTES) ? 3'd0 : 3'(last);
    in_dllp     = dllp;
    in_nullify  = nul;
    for (int i = 0; i < BYTES; i++) begin
      if (BYTES * k + i < pb.size())
        in_data[8*i +: 8] = pb[BYTES*k+i];
      else
        in_data[8*i +: 8] = 8'($urandom);
    end
  endtask

  task automatic send_pkt(string tag, int len, logic dllp,
                          logic nul, logic zc);
    int nin;
    restart();
    make_pkt(len);
    frame(dllp ? K_SDP : K_STP, len, (nul && !dllp) ? K_EDB : K_END);
    nin = (len + BYTES - 1) / BYTES;
    for (int k = 0; k < 7; k++) begin
      if (k < nin)
        drive_word(k, dllp, nul, zc);
      else
        idle_in();
      #1;
      check({tag, "_rdy"}, 64'(in_ready),
            64'((k == nin && fw.size() > nin) ? 0 : 1));
      if (k < fw.size())
        step(fw[k]);
      else
        step(idle_e(1'b1));
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    idle_in();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("reset_rdy", 64'(in_ready), 64'(0));
      step(idle_e(1'b0));
    end
    rst = 1'b0;

    send_pkt("dllp6", 6, 1'b1, 1'b0, 1'b0);
    send_pkt("tlp16", 16, 1'b0, 1'b0, 1'b0);
    send_pkt("null15", 15, 1'b0, 1'b1, 1'b0);
    send_pkt("one3", 3, 1'b0, 1'b0, 1'b0);
    send_pkt("dllp2", 2, 1'b1, 1'b0, 1'b0);
    send_pkt("one1", 1, 1'b0, 1'b0, 1'b0);
    send_pkt("cnt0", 20, 1'b0, 1'b0, 1'b1);
    send_pkt("dllpnul", 8, 1'b1, 1'b1, 1'b0);
    send_pkt("null4", 4, 1'b0, 1'b1, 1'b0);

    // Underrun after the second word; rest of packet is dropped.
    restart();
    make_pkt(16);
    frame(K_STP, 8, K_EDB);
    fw[2].urun = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 2)
        drive_word(k, 1'b0, 1'b0, 1'b0);
      else if (k == 3 || k == 4)
        drive_word(k - 1, 1'b0, 1'b0, 1'b0);
      else
        idle_in();
      #1;
      check("urun_rdy", 64'(in_ready), 64'(1));
      if (k < 3)
        step(fw[k]);
      else
        step(idle_e(1'b1));
    end

    // Idle link: SKP ordered set every 8 enabled cycles.
    restart();
    for (int k = 0; k < 26; k++) begin
      idle_in();
      #1;
      check("skp_rdy", 64'(in_ready),
            64'((k >= 8 && (k % 8 == 0 || k % 8 == 1)) ? 0 : 1));
      if (k >= 8 && k % 8 == 0)
        step(com_e());
      else
        step(idle_e(1'b1));
    end

    // Expiry during a packet waits for the TAIL word.
    restart();
    make_pkt(16);
    frame(K_STP, 16, K_END);
    for (int k = 0; k < 12; k++) begin
      if (k >= 4 && k < 8)
        drive_word(k - 4, 1'b0, 1'b0, 1'b0);
      else
        idle_in();
      #1;
      check("skppkt_rdy", 64'(in_ready), 64'((k >= 8 && k <= 10) ? 0 : 1));
      if (k >= 4 && k <= 8)
        step(fw[k-4]);
      else if (k == 9)
        step(com_e());
      else
        step(idle_e(1'b1));
    end

    // Synchronous reset in the middle of a packet.
    restart();
    make_pkt(12);
    frame(K_STP, 12, K_END);
    drive_word(0, 1'b0, 1'b0, 1'b0);
    step(fw[0]);
    drive_word(1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_rdy", 64'(in_ready), 64'(0));
    step(idle_e(1'b0));
    idle_in();
    #1;
    check("rst_rdy2", 64'(in_ready), 64'(0));
    step(idle_e(1'b0));
    rst = 1'b0;
    #1;
    check("rst_rel_rdy", 64'(in_ready), 64'(1));
    step(idle_e(1'b1));
    step(idle_e(1'b1));

    // Link drop mid-packet: no END, no underrun.
    restart();
    make_pkt(12);
    frame(K_STP, 12, K_END);
    drive_word(0, 1'b0, 1'b0, 1'b0);
    step(fw[0]);
    drive_word(1, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    #1;
    check("enoff_rdy", 64'(in_ready), 64'(0));
    step(idle_e(1'b0));
    en = 1'b1;
    drive_word(2, 1'b0, 1'b0, 1'b0);
    #1;
    check("enon_rdy", 64'(in_ready), 64'(1));
    step(idle_e(1'b1));
    idle_in();
    step(idle_e(1'b1));
    step(idle_e(1'b1));

    check("drain", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_packet_framer.md
Name: tx_packet_framer

Overview:
- Transmit-side Gen1/Gen2 (8b/10b) framer for the PHY logical layer, the counterpart of the receive-side packet identification.
- Accepts TLP/DLLP byte words from the data link layer and emits symbols with per-byte D/K flags toward the PIPE TX path:
  - inserts STP/SDP start, END/EDB end and PAD fill;
  - drives logical idle between packets;
  - inserts periodic SKP ordered sets.
- Single logical byte stream; lane striping is done downstream.

Parameters:
- BYTES, 4, bytes per bus word; legal values 2 or 4.
- SKP_INTERVAL, 295, enabled cycles between SKP ordered-set requests (1180 symbols / 4). Must be 4 or more.
- CNT_W, 16, width of the SKP interval counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  link up / transmit enable.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  framer accepts word (combinational from registered state, skp_pending and en).
- in_data  in  8*BYTES  packet bytes; byte0 = bits[7:0] is the first byte in time.
- in_sop  in  1  first word of packet.
- in_eop  in  1  last word of packet.
- in_last_cnt  in  3  valid bytes in the eop word, 1..BYTES (ignored when in_eop=0).
- in_dllp  in  1  packet is a DLLP (sampled with sop).
- in_nullify  in  1  TLP ends with EDB (sampled with eop; ignored for DLLP).
- out_data  out  8*BYTES  framed symbols.
- out_dk  out  BYTES  1 = K symbol for that byte.
- out_valid  out  1  registered copy of en.
- underrun  out  1  one-cycle pulse when a packet is aborted.

Behaviour:
- Symbols (D/K flags):
  - STP=FB K, SDP=5C K, END=FD K, EDB=FE K, PAD=F7 K.
  - COM=BC K, SKP=1C K.
  - Idle = 00 D.
- Reset values: out_data=0, out_dk=0, out_valid=0, underrun=0, state=IDLE, carry=0, tail=0, counter=0, skp_pending=0. While rst=1, in_ready=0.
- Latency: all outputs are registered. A word accepted at cycle t appears on out_data at t+1.
- States: IDLE, PKT, TAIL, DROP, SKP.
- IDLE:
  - in_ready=1 unless skp_pending.
  - No accepted sop: emit all-idle word.
  - Accepted sop: byte0 = STP (or SDP if in_dllp), bytes1..BYTES-1 = in bytes 0..BYTES-2, carry = in byte BYTES-1, go PKT.
  - in_valid without in_sop: word discarded.
- PKT, in_ready=1:
  - Accepted non-eop word: out = {carry, in bytes 0..BYTES-2}; carry = last byte.
- Eop handling (either state), with n = in_last_cnt and pending bytes = leading symbol (start or carry) + n data + END:
  - n+2 <= BYTES: single word, PAD fill to the end, go IDLE.
  - n = BYTES-1: data fills the word; TAIL emits {END, PAD...}.
  - n = BYTES: TAIL emits {last data, END, PAD...}.
- End symbol: END, or EDB when in_nullify=1 and in_dllp=0.
- TAIL: in_ready=0, one cycle, then IDLE.
- Underrun (PKT with in_valid=0):
  - Emit {carry, EDB, PAD...} and pulse underrun.
  - Go DROP, or IDLE if that word was already the eop.
- DROP: in_ready=1, accepted words discarded, idle emitted; on accepted eop go IDLE.
- SKP scheduling:
  - Counter increments every cycle while en=1.
  - At SKP_INTERVAL-1 the counter resets to 0 and sets skp_pending.
  - A further expiry while pending is dropped, not queued.
  - Taken only from IDLE; a packet in progress is never interrupted.
  - SKP has priority over a simultaneous sop (in_ready=0).
  - SKP state emits COM,SKP,SKP,SKP over 4/BYTES cycles with in_ready=0, clears skp_pending, returns to IDLE.
- en=0:
  - Next cycle: state=IDLE, counter=0, skp_pending=0, out_valid=0, out word all-idle, in_ready=0.
  - A packet in flight is abandoned with no END and no underrun pulse.
- in_sop inside PKT is treated as data. in_last_cnt=0 is treated as BYTES.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - symbol constants (K_STP, K_SDP, K_END, K_EDB, K_PAD, K_COM, K_SKP, D_IDLE);
  - framer state encodings.
- One sub-module: tx_skp_scheduler, containing the counter and skp_pending with a skp_taken clear input.

Test Plan:
- DLLP, BYTES=4:
  - Stimulus: sop word {a0,a1,a2,a3}, then eop {a4,a5} with n=2.
  - Response: out {5C,a0,a1,a2} dk=0001, {a3,a4,a5,FD} dk=1000, then {00,00,00,00} dk=0000.
- 16-byte TLP, n=4 on the eop word:
  - Response: {FB,d0,d1,d2}, {d3..d6}, {d7..d10}, {d11..d14}, then TAIL {d15,FD,F7,F7} dk=1110.
  - in_ready=0 in the TAIL cycle.
- Nullified 15-byte TLP, n=3:
  - Response: last data word {d11,d12,d13,d14}, then TAIL {FE,F7,F7,F7} dk=1111.
- SKP, SKP_INTERVAL=8, idle link:
  - Response: {BC,1C,1C,1C} dk=1111 every 8 cycles, in_ready=0 that cycle.
  - An expiry during a packet: SKP appears the cycle after END/TAIL.
- Underrun:
  - Stimulus: in_valid=0 after the second word of a TLP.
  - Response: {carry,FE,F7,F7}, underrun=1 for one cycle; remaining words through eop discarded with idle output.
- Reset and en mid-packet:
  - rst=1 in PKT: next cycle out_data=0, out_dk=0, out_valid=0, in_ready=0.
  - en=0 in PKT: next cycle idle, no END, no underrun.
